ahb_slave_interface: RTL and testbench
======================================

# ahb_slave_interface

AHB-Lite slave front end of the AHB-to-APB bridge: samples the AHB address/control/data pipeline, decodes the target APB peripheral and produces the `valid`, pipelined address/data and `hwrite_reg` signals consumed by the APB controller. It returns read data and the combined ready/response to the AHB master. An optional two-cycle ERROR response handles unmapped addresses.

## Interface
Parameters:
- `BASE0` = 32'h8000_0000: base of peripheral 0 region (64 MiB)
- `BASE1` = 32'h8400_0000: base of peripheral 1 region (64 MiB)
- `BASE2` = 32'h8800_0000: base of peripheral 2 region (64 MiB)

Ports:
- `hclk`  in  1  bus clock, all state on rising edge
- `hresetn`  in  1  reset, asynchronous, active-low
- `hwrite`  in  1  AHB transfer direction, 1 = write
- `hreadyin`  in  1  AHB HREADY from interconnect
- `htrans`  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- `haddr`  in  32  AHB address
- `hwdata`  in  32  AHB write data (data phase)
- `prdata`  in  32  APB read data
- `hr_readyout`  in  1  ready from APB controller
- `valid`  out  1  mapped NONSEQ/SEQ address phase accepted (combinational)
- `tempselx`  out  3  one-hot peripheral select (combinational)
- `haddr1`, `haddr2`  out  32  haddr delayed 1 / 2 cycles
- `hwdata1`, `hwdata2`  out  32  hwdata delayed 1 / 2 cycles
- `hwrite_reg`, `hwrite_reg1`  out  1  hwrite delayed 1 / 2 cycles
- `hrdata`  out  32  read data to master
- `hresp`  out  2  00 OKAY, 01 ERROR
- `hreadyout`  out  1  ready to master

## Operation
- Transfer phase: `xfer = hreadyin & htrans[1]`; IDLE and BUSY never produce `valid`.
- Decode on `haddr[31:26]`: BASE0 -> `tempselx=3'b001`, BASE1 -> `3'b010`, BASE2 -> `3'b100`, else `3'b000` (`hit=0`).
- `valid = xfer & hit & (err_state==OK)`.
- Pipeline registers (`haddr1/2`, `hwdata1/2`, `hwrite_reg/1`) shift every cycle unconditionally; no enable.
- `hrdata = prdata` (combinational pass-through).
- Error FSM, states OK, ERR1, ERR2:
  - OK -> ERR1 when `xfer & ~hit`.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> OK unconditionally. A new `xfer & ~hit` seen in ERR2 is not re-flagged; the master must cancel after ERROR per AHB.
- Outputs by state: OK: `hresp=00`, `hreadyout=hr_readyout`. ERR1: `hresp=01`, `hreadyout=0`. ERR2: `hresp=01`, `hreadyout=1`.
- Widths: all address/data paths 32 bit, no arithmetic.

## Timing
- Async reset values: `haddr1/2=0`, `hwdata1/2=0`, `hwrite_reg/1=0`, FSM=OK, so `hresp=00` and `hreadyout=hr_readyout`. Combinational outputs follow inputs while in reset; `valid=0` is not forced.
- Latency: `valid`/`tempselx` 0 cycles. `haddr1`/`hwdata1`/`hwrite_reg` 1 cycle. `*2`/`hwrite_reg1` 2 cycles.
- Error response: unmapped address phase at edge N -> ERR1 during cycle N+1 (hreadyout low) -> ERR2 during N+2 (hreadyout high) -> OK at N+3.
- Reset mid-error: FSM returns to OK immediately; `hresp` goes to 00 asynchronously.
- `hreadyin=0` with NONSEQ: no valid, no error entry.

## Configuration
- `AHB_ERR_RESP_EN` defined: error FSM compiled in as above.
- Not defined: FSM removed. Unmapped transfers are silently ignored: `valid=0`, `hresp=00` always, `hreadyout=hr_readyout` always.

## Test plan
- Reset: assert `hresetn=0` mid-cycle -> pipeline regs 0 and `hresp=00` immediately, without waiting for a clock edge.
- Mapped write: NONSEQ write `haddr=32'h8400_0010`, then `hwdata=32'hA5A5_0001` -> `valid=1`, `tempselx=010` in that cycle. Next cycle: `haddr1=32'h8400_0010`, `hwrite_reg=1`. One cycle later: `hwdata1=32'hA5A5_0001`.
- Back-to-back SEQ reads at `32'h8000_0000`, `0x4`, `0x8` -> `valid=1` each cycle. `haddr2` equals the address from two cycles earlier. `hrdata` tracks `prdata=32'hDEAD_BEEF`.
- IDLE/BUSY/`hreadyin=0`: `htrans=00`, then `01`, then NONSEQ with `hreadyin=0`, all at a mapped address -> `valid=0` throughout.
- Unmapped with `AHB_ERR_RESP_EN`: NONSEQ `haddr=32'h9000_0000` -> next cycle `hresp=01`/`hreadyout=0`, then `hresp=01`/`hreadyout=1`, then `hresp=00`. `valid=0` in all three cycles.
- Unmapped without macro: same stimulus -> `hresp=00` throughout, `valid=0`, `hreadyout` equals `hr_readyout`.

Source files
------------

// File: rtl/ahb_slave_interface.sv
// ============================================================================
// ahb_slave_interface
// ----------------------------------------------------------------------------
// AHB-Lite slave front end of the AHB-to-APB bridge. It samples the AHB
// address/control/data pipeline and decodes which APB peripheral is targeted.
// It produces the accept strobe, the delayed address/data/direction signals
// used by the APB controller, and the read data plus ready/response returned
// to the AHB master.
//
// Optional feature macro: AHB_ERR_RESP_EN
//   defined     : unmapped transfers get a two-cycle AHB ERROR response
//                 (OK -> ERR1 -> ERR2 -> OK).
//   not defined : unmapped transfers are silently ignored. hresp is always
//                 OKAY and hreadyout always follows hr_readyout.
//
// Parameters:
//   BASE0/1/2    base address of each 64 MiB peripheral region. Only bits
//                [31:26] take part in the decode.
//
// Ports:
//   hclk         bus clock; all state updates on the rising edge
//   hresetn      asynchronous active-low reset
//   hwrite       transfer direction, 1 = write
//   hreadyin     HREADY from the interconnect
//   htrans       transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   haddr        AHB address
//   hwdata       AHB write data, valid in the data phase
//   prdata       APB read data
//   hr_readyout  ready from the APB controller
//   valid        a mapped NONSEQ/SEQ address phase is accepted (combinational)
//   tempselx     one-hot peripheral select (combinational)
//   haddr1/2     haddr delayed by 1 and 2 cycles
//   hwdata1/2    hwdata delayed by 1 and 2 cycles
//   hwrite_reg   hwrite delayed by 1 cycle
//   hwrite_reg1  hwrite delayed by 2 cycles
//   hrdata       read data to the master (prdata pass-through)
//   hresp        response to the master, 00 OKAY, 01 ERROR
//   hreadyout    ready to the master
// ============================================================================
module ahb_slave_interface #(
  parameter logic [31:0] BASE0 = 32'h8000_0000,
  parameter logic [31:0] BASE1 = 32'h8400_0000,
  parameter logic [31:0] BASE2 = 32'h8800_0000
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  input  logic        hr_readyout,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] haddr1,
  output logic [31:0] haddr2,
  output logic [31:0] hwdata1,
  output logic [31:0] hwdata2,
  output logic        hwrite_reg,
  output logic        hwrite_reg1,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hreadyout
);

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  logic xfer;
  logic hit;

  // htrans[1] is set for NONSEQ and SEQ only, so IDLE and BUSY never count
  // as a transfer. A stalled bus (hreadyin low) does not count either.
  assign xfer = hreadyin & htrans[1];

  // Region decode on the top six address bits. Each region is 64 MiB wide.
  // The first matching base wins if two bases were ever configured to
  // overlap, which keeps tempselx strictly one-hot.
  always_comb begin
    tempselx = 3'b000;
    if (haddr[31:26] == BASE0[31:26]) begin
      tempselx = 3'b001;
    end else if (haddr[31:26] == BASE1[31:26]) begin
      tempselx = 3'b010;
    end else if (haddr[31:26] == BASE2[31:26]) begin
      tempselx = 3'b100;
    end
  end

  assign hit = |tempselx;

  // Read data goes straight back to the master. The APB controller
  // qualifies it through hr_readyout.
  assign hrdata = prdata;

  // Address, data and direction pipelines. They shift every cycle with no
  // enable. The APB controller picks the stage it needs based on its own
  // state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1      <= 32'h0000_0000;
      haddr2      <= 32'h0000_0000;
      hwdata1     <= 32'h0000_0000;
      hwdata2     <= 32'h0000_0000;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
    end else begin
      haddr1      <= haddr;
      haddr2      <= haddr1;
      hwdata1     <= hwdata;
      hwdata2     <= hwdata1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
    end
  end

`ifdef AHB_ERR_RESP_EN

  typedef enum logic [1:0] {
    OK   = 2'b00,
    ERR1 = 2'b01,
    ERR2 = 2'b10
  } err_state_t;

  err_state_t err_state;
  err_state_t err_next;

  // Error response state. Reset puts it back to OK at once, so hresp drops
  // to OKAY asynchronously even in the middle of an ERROR response.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      err_state <= OK;
    end else begin
      err_state <= err_next;
    end
  end

  // The AHB ERROR response takes two cycles. In the first cycle HREADY is
  // low with ERROR, and in the second HREADY is high with ERROR. An
  // unmapped transfer seen during ERR2 is not flagged again, because the
  // master is expected to cancel its pipelined transfer after an ERROR.
  always_comb begin
    err_next  = err_state;
    hresp     = RESP_OKAY;
    hreadyout = hr_readyout;
    case (err_state)
      OK: begin
        if (xfer && !hit) begin
          err_next = ERR1;
        end
      end
      ERR1: begin
        hresp     = RESP_ERROR;
        hreadyout = 1'b0;
        err_next  = ERR2;
      end
      ERR2: begin
        hresp     = RESP_ERROR;
        hreadyout = 1'b1;
        err_next  = OK;
      end
      default: begin
        err_next = OK;
      end
    endcase
  end

  // New transfers are blocked while an ERROR response is in progress.
  assign valid = xfer & hit & (err_state == OK);

`else

  // Without the error response, unmapped transfers are dropped. They give
  // no valid and the master always sees OKAY.
  assign valid     = xfer & hit;
  assign hresp     = RESP_OKAY;
  assign hreadyout = hr_readyout;

`endif

endmodule

// File: tb/tb_ahb_slave_interface.sv
// ============================================================================
// tb_ahb_slave_interface
// ----------------------------------------------------------------------------
// Directed self-checking bench for ahb_slave_interface. Inputs change on the
// falling edge of hclk. Combinational outputs are checked 1 ns after the
// inputs change. Registered outputs are checked on the falling edge that
// follows the rising edge that captured them. Expected values for the
// error response depend on whether AHB_ERR_RESP_EN is defined.
// ============================================================================
module tb_ahb_slave_interface;

`ifdef AHB_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        hr_readyout;
  logic        valid;
  logic [2:0]  tempselx;
  logic [31:0] haddr1;
  logic [31:0] haddr2;
  logic [31:0] hwdata1;
  logic [31:0] hwdata2;
  logic        hwrite_reg;
  logic        hwrite_reg1;
  logic [31:0] hrdata;
  logic [1:0]  hresp;
  logic        hreadyout;

  int check_count;
  int pass_count;

  ahb_slave_interface dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .hwrite      (hwrite),
    .hreadyin    (hreadyin),
    .htrans      (htrans),
    .haddr       (haddr),
    .hwdata      (hwdata),
    .prdata      (prdata),
    .hr_readyout (hr_readyout),
    .valid       (valid),
    .tempselx    (tempselx),
    .haddr1      (haddr1),
    .haddr2      (haddr2),
    .hwdata1     (hwdata1),
    .hwdata2     (hwdata2),
    .hwrite_reg  (hwrite_reg),
    .hwrite_reg1 (hwrite_reg1),
    .hrdata      (hrdata),
    .hresp       (hresp),
    .hreadyout   (hreadyout)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Async reset from power-up. Then load the pipeline with non-zero values
  // and pull reset in the middle of a high phase. The registers and hresp
  // must clear at once, without waiting for a clock edge.
  task automatic test_reset();
    hresetn     = 1'b0;
    hwrite      = 1'b0;
    hreadyin    = 1'b1;
    htrans      = 2'b00;
    haddr       = 32'h0;
    hwdata      = 32'h0;
    prdata      = 32'h0;
    hr_readyout = 1'b1;
    #12;
    check_count++;
    if (haddr2 !== 32'h0) $display("[TB] FAIL reset_haddr2 got=%h exp=%h", haddr2, 32'h0);
    else pass_count++;
    check_count++;
    if (hresp !== 2'b00) $display("[TB] FAIL reset_hresp got=%b exp=%b", hresp, 2'b00);
    else pass_count++;
    @(negedge hclk);
    hresetn = 1'b1;
    htrans  = 2'b10;
    hwrite  = 1'b1;
    haddr   = 32'h8000_0004;
    hwdata  = 32'h1234_5678;
    @(negedge hclk);
    htrans  = 2'b00;
    haddr   = 32'h8800_0000;
    @(negedge hclk);
    @(posedge hclk);
    #2;
    hresetn = 1'b0;
    #1;
    check_count++;
    if ({haddr1, haddr2} !== 64'h0) $display("[TB] FAIL midcycle_haddr got=%h/%h exp=0/0", haddr1, haddr2);
    else pass_count++;
    check_count++;
    if ({hwdata1, hwdata2} !== 64'h0) $display("[TB] FAIL midcycle_hwdata got=%h/%h exp=0/0", hwdata1, hwdata2);
    else pass_count++;
    check_count++;
    if ({hwrite_reg, hwrite_reg1} !== 2'b00) $display("[TB] FAIL midcycle_hwrite got=%b%b exp=00", hwrite_reg, hwrite_reg1);
    else pass_count++;
    check_count++;
    if (hresp !== 2'b00 || hreadyout !== 1'b1) $display("[TB] FAIL midcycle_resp got=%b/%b exp=00/1", hresp, hreadyout);
    else pass_count++;
    @(negedge hclk);
    hresetn = 1'b1;
    hwrite  = 1'b0;
    hwdata  = 32'h0;
  endtask

  // NONSEQ write to peripheral 1, then the write data in the data phase.
  task automatic test_mapped_write();
    @(negedge hclk);
    htrans   = 2'b10;
    hwrite   = 1'b1;
    hreadyin = 1'b1;
    haddr    = 32'h8400_0010;
    #1;
    check_count++;
    if (valid !== 1'b1) $display("[TB] FAIL write_valid got=%b exp=1", valid);
    else pass_count++;
    check_count++;
    if (tempselx !== 3'b010) $display("[TB] FAIL write_tempselx got=%b exp=010", tempselx);
    else pass_count++;
    @(negedge hclk);
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0000_0000;
    hwdata = 32'hA5A5_0001;
    #1;
    check_count++;
    if (haddr1 !== 32'h8400_0010) $display("[TB] FAIL write_haddr1 got=%h exp=%h", haddr1, 32'h8400_0010);
    else pass_count++;
    check_count++;
    if (hwrite_reg !== 1'b1) $display("[TB] FAIL write_hwrite_reg got=%b exp=1", hwrite_reg);
    else pass_count++;
    @(negedge hclk);
    hwdata = 32'h0;
    #1;
    check_count++;
    if (hwdata1 !== 32'hA5A5_0001) $display("[TB] FAIL write_hwdata1 got=%h exp=%h", hwdata1, 32'hA5A5_0001);
    else pass_count++;
    check_count++;
    if (haddr2 !== 32'h8400_0010 || hwrite_reg1 !== 1'b1) $display("[TB] FAIL write_stage2 got=%h/%b exp=84000010/1", haddr2, hwrite_reg1);
    else pass_count++;
    @(negedge hclk);
    #1;
    check_count++;
    if (hwdata2 !== 32'hA5A5_0001) $display("[TB] FAIL write_hwdata2 got=%h exp=%h", hwdata2, 32'hA5A5_0001);
    else pass_count++;
  endtask

  // Three back-to-back reads from peripheral 0 with a fixed APB read value.
  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h8000_0000;
    addrs[1] = 32'h8000_0004;
    addrs[2] = 32'h8000_0008;
    prdata   = 32'hDEAD_BEEF;
    hwrite   = 1'b0;
    hreadyin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      htrans = (i == 0) ? 2'b10 : 2'b11;
      haddr  = addrs[i];
      #1;
      check_count++;
      if (valid !== 1'b1 || tempselx !== 3'b001) $display("[TB] FAIL b2b_valid[%0d] got=%b/%b exp=1/001", i, valid, tempselx);
      else pass_count++;
      if (i == 2) begin
        check_count++;
        if (haddr2 !== addrs[0]) $display("[TB] FAIL b2b_haddr2 got=%h exp=%h", haddr2, addrs[0]);
        else pass_count++;
      end
    end
    check_count++;
    if (hrdata !== 32'hDEAD_BEEF) $display("[TB] FAIL b2b_hrdata got=%h exp=%h", hrdata, 32'hDEAD_BEEF);
    else pass_count++;
    @(negedge hclk);
    htrans = 2'b00;
    prdata = 32'h0BAD_F00D;
    #1;
    check_count++;
    if (haddr2 !== addrs[1] || haddr1 !== addrs[2]) $display("[TB] FAIL b2b_pipe got=%h/%h exp=%h/%h", haddr1, haddr2, addrs[2], addrs[1]);
    else pass_count++;
    check_count++;
    if (hrdata !== 32'h0BAD_F00D) $display("[TB] FAIL b2b_hrdata_track got=%h exp=%h", hrdata, 32'h0BAD_F00D);
    else pass_count++;
  endtask

  // IDLE, BUSY and a stalled NONSEQ to a mapped address never give valid.
  // A stalled unmapped NONSEQ must not start an ERROR response.
  task automatic test_idle_busy_stall();
    logic [1:0] trans_vec [3];
    logic       ready_vec [3];
    trans_vec[0] = 2'b00; ready_vec[0] = 1'b1;
    trans_vec[1] = 2'b01; ready_vec[1] = 1'b1;
    trans_vec[2] = 2'b10; ready_vec[2] = 1'b0;
    hr_readyout = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      htrans   = trans_vec[i];
      hreadyin = ready_vec[i];
      haddr    = 32'h8800_0000;
      #1;
      check_count++;
      if (valid !== 1'b0) $display("[TB] FAIL idle_valid[%0d] got=%b exp=0", i, valid);
      else pass_count++;
    end
    check_count++;
    if (tempselx !== 3'b100) $display("[TB] FAIL idle_tempselx got=%b exp=100", tempselx);
    else pass_count++;
    @(negedge hclk);
    haddr = 32'h9000_0000;
    @(negedge hclk);
    htrans   = 2'b00;
    hreadyin = 1'b1;
    #1;
    check_count++;
    if (hresp !== 2'b00 || hreadyout !== 1'b1) $display("[TB] FAIL stall_no_err got=%b/%b exp=00/1", hresp, hreadyout);
    else pass_count++;
  endtask

  // Unmapped NONSEQ. With the error response enabled this gives ERR1, then
  // ERR2, then OK. An unmapped NONSEQ seen during ERR2 is not flagged
  // again. hr_readyout is held low during the first two cycles so that the
  // forced-high ERR2 ready can be told apart from the pass-through.
  task automatic test_unmapped();
    @(negedge hclk);
    htrans      = 2'b10;
    hreadyin    = 1'b1;
    haddr       = 32'h9000_0000;
    hr_readyout = 1'b1;
    #1;
    check_count++;
    if (valid !== 1'b0 || tempselx !== 3'b000) $display("[TB] FAIL unmap_decode got=%b/%b exp=0/000", valid, tempselx);
    else pass_count++;
    @(negedge hclk);
    htrans      = 2'b00;
    hr_readyout = 1'b0;
    #1;
    check_count++;
    if (hresp !== (ERR_EN ? 2'b01 : 2'b00) || hreadyout !== 1'b0 || valid !== 1'b0)
      $display("[TB] FAIL unmap_cycle1 got=%b/%b/%b exp=%b/0/0", hresp, hreadyout, valid, ERR_EN ? 2'b01 : 2'b00);
    else pass_count++;
    @(negedge hclk);
    htrans = 2'b10;
    #1;
    check_count++;
    if (hresp !== (ERR_EN ? 2'b01 : 2'b00) || hreadyout !== ERR_EN || valid !== 1'b0)
      $display("[TB] FAIL unmap_cycle2 got=%b/%b/%b exp=%b/%b/0", hresp, hreadyout, valid, ERR_EN ? 2'b01 : 2'b00, ERR_EN);
    else pass_count++;
    @(negedge hclk);
    htrans      = 2'b00;
    hr_readyout = 1'b1;
    #1;
    check_count++;
    if (hresp !== 2'b00 || hreadyout !== 1'b1 || valid !== 1'b0)
      $display("[TB] FAIL unmap_cycle3 got=%b/%b/%b exp=00/1/0", hresp, hreadyout, valid);
    else pass_count++;
  endtask

  // Reset pulled during ERR1 must return hresp to OKAY without a clock edge.
  task automatic test_reset_mid_error();
    @(negedge hclk);
    htrans   = 2'b10;
    hreadyin = 1'b1;
    haddr    = 32'h9000_0000;
    @(negedge hclk);
    htrans = 2'b00;
    #1;
    check_count++;
    if (hresp !== (ERR_EN ? 2'b01 : 2'b00)) $display("[TB] FAIL err_entry got=%b exp=%b", hresp, ERR_EN ? 2'b01 : 2'b00);
    else pass_count++;
    #1;
    hresetn = 1'b0;
    #1;
    check_count++;
    if (hresp !== 2'b00 || hreadyout !== 1'b1) $display("[TB] FAIL err_reset got=%b/%b exp=00/1", hresp, hreadyout);
    else pass_count++;
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    test_reset();
    test_mapped_write();
    test_back_to_back();
    test_idle_busy_stall();
    test_unmapped();
    test_reset_mid_error();
    repeat (2) @(negedge hclk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
